framed_rotation_sipo: RTL and testbench

Serial-to-parallel deserializer for the registers library. It assembles words from a qualified serial bit stream, with runtime-selectable bit order and right-rotation. Each completed word is emitted automatically through a valid/ready output port. Frame-sync input realigns word boundaries; sticky flags report overrun and misalignment. It replaces manual enable/load sequencing in serial receive paths.

---
 rtl/framed_rotation_sipo_if.sv | 31 +++
 rtl/framed_rotation_sipo.sv | 161 ++++++++++++++++
 tb/tb_framed_rotation_sipo.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/framed_rotation_sipo_if.sv
// Serial input stream and completed-word output handshake for framed_rotation_sipo.
// The slave modport is the deserializer's view; the master modport is the
// producer of serial bits and the consumer of completed words.
interface framed_rotation_sipo_if #(
  parameter int WIDTH = 8
);
  logic             serial_in;
  logic             bit_valid;
  logic             frame_start;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output serial_in,
    output bit_valid,
    output frame_start,
    output out_ready,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  serial_in,
    input  bit_valid,
    input  frame_start,
    input  out_ready,
    output out_data,
    output out_valid
  );
endinterface

// File: rtl/framed_rotation_sipo.sv
// Serial-to-parallel deserializer: assembles WIDTH-bit words from a qualified
// bit stream with per-word selectable bit order, rotates each completed word
// right by a runtime amount and presents it on a valid/ready output register.
// frame_start realigns word boundaries; overrun and align_err are sticky.
module framed_rotation_sipo #(
  parameter  int WIDTH = 8,
  localparam int RW    = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_msb_first,
  input  logic [RW-1:0]         i_rot_amt,
  framed_rotation_sipo_if.slave bus,
  output logic [RW-1:0]         o_bit_count,
  output logic                  o_overrun,
  output logic                  o_align_err
);

  // Assembly state
  logic [WIDTH-1:0]   r_sreg;
  logic [RW-1:0]      r_bit_count;
  logic               r_msb_first;
  // Output register and sticky status
  logic [WIDTH-1:0]   r_out_data;
  logic               r_out_valid;
  logic               r_overrun;
  logic               r_align_err;

  // Combinational datapath
  logic               w_accept;
  logic               w_first;
  logic               w_order;
  logic [WIDTH-1:0]   w_base;
  logic [WIDTH-1:0]   w_shift;
  logic               w_complete;
  logic [RW-1:0]      w_next_count;
  logic               w_align_set;
  logic [RW-1:0]      w_rot;
  logic [2*WIDTH-1:0] w_dbl;
  logic [WIDTH-1:0]   w_rotated;
  logic               w_load;
  logic               w_drop;
  logic               w_consume;

  // Next bit-count, shifted word, rotation and output-register decisions
  always_comb begin
    w_accept     = bus.bit_valid;
    w_first      = 1'b0;
    w_order      = r_msb_first;
    w_base       = r_sreg;
    w_shift      = r_sreg;
    w_complete   = 1'b0;
    w_next_count = r_bit_count;
    w_align_set  = 1'b0;
    w_rot        = RW'(int'(i_rot_amt) % WIDTH);
    w_dbl        = {2*WIDTH{1'b0}};
    w_rotated    = {WIDTH{1'b0}};
    w_load       = 1'b0;
    w_drop       = 1'b0;
    w_consume    = 1'b0;

    if (w_accept) begin
      // A frame_start bit or the bit at count 0 opens a new word; the order
      // is taken from the live input for that bit and latched for the rest.
      w_first = bus.frame_start || (r_bit_count == {RW{1'b0}});
      if (w_first) begin
        w_order = i_msb_first;
        w_base  = {WIDTH{1'b0}};
      end else begin
        w_order = r_msb_first;
        w_base  = r_sreg;
      end

      if (w_order) begin
        w_shift = {w_base[WIDTH-2:0], bus.serial_in};
      end else begin
        w_shift = {bus.serial_in, w_base[WIDTH-1:1]};
      end

      // A frame_start on the last bit position still realigns instead of completing.
      w_align_set = bus.frame_start && (r_bit_count != {RW{1'b0}});
      w_complete  = !bus.frame_start && (r_bit_count == RW'(WIDTH - 1));

      if (bus.frame_start) begin
        w_next_count = RW'(1);
      end else if (w_complete) begin
        w_next_count = {RW{1'b0}};
      end else begin
        w_next_count = r_bit_count + RW'(1);
      end
    end else begin
      w_first = 1'b0;
    end

    // Right rotation: the low half of the doubled word shifted right.
    w_dbl     = {w_shift, w_shift} >> w_rot;
    w_rotated = w_dbl[WIDTH-1:0];

    if (w_complete) begin
      w_load = !r_out_valid || bus.out_ready;
      w_drop = r_out_valid && !bus.out_ready;
    end else begin
      w_consume = r_out_valid && bus.out_ready;
    end
  end

  // Shift register, bit counter, latched bit order and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg      <= {WIDTH{1'b0}};
      r_bit_count <= {RW{1'b0}};
      r_msb_first <= 1'b0;
      r_overrun   <= 1'b0;
      r_align_err <= 1'b0;
    end else if (i_clear) begin
      r_sreg      <= {WIDTH{1'b0}};
      r_bit_count <= {RW{1'b0}};
      r_msb_first <= 1'b0;
      r_overrun   <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sreg      <= w_shift;
        r_bit_count <= w_next_count;
      end
      if (w_first) begin
        r_msb_first <= i_msb_first;
      end
      if (w_align_set) begin
        r_align_err <= 1'b1;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Output register: load on free slot or same-cycle consume, clear valid on consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
    end else if (i_clear) begin
      r_out_data  <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= w_rotated;
      r_out_valid <= 1'b1;
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign o_bit_count   = r_bit_count;
  assign o_overrun     = r_overrun;
  assign o_align_err   = r_align_err;

endmodule

// File: tb/tb_framed_rotation_sipo.sv
// Self-checking bench for framed_rotation_sipo: directed cases for the known
// words and boundary behaviour, then randomized traffic, all compared against
// a bit-list reference model of the deserializer.
module tb_framed_rotation_sipo;
  localparam int W  = 8;
  localparam int RW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          msb_first;
  logic [RW-1:0] rot_amt;
  logic [RW-1:0] bit_count;
  logic          overrun;
  logic          align_err;

  framed_rotation_sipo_if #(.WIDTH(W)) bus ();

  framed_rotation_sipo #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (clear),
    .i_msb_first (msb_first),
    .i_rot_amt   (rot_amt),
    .bus         (bus),
    .o_bit_count (bit_count),
    .o_overrun   (overrun),
    .o_align_err (align_err)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  string phase = "reset";

  // Reference model: list of bits received for the current word.
  int         m_cnt;
  bit         m_order;
  bit         m_bits[W];
  logic [W-1:0] m_data;
  bit         m_valid;
  bit         m_ovr;
  bit         m_aln;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s/%s: got=%0h expected=%0h", phase, tag, got, exp);
    end
  endtask

  // Word value: bit i of the stream lands at position W-1-i (MSB first) or i (LSB first).
  function automatic logic [W-1:0] assemble(input bit order);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W; i++) begin
      if (m_bits[i]) v = v + (order ? (W'(1) << (W - 1 - i)) : (W'(1) << i));
    end
    return v;
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input int r);
    logic [W-1:0] o;
    int k;
    k = r % W;
    for (int j = 0; j < W; j++) o[j] = v[(j + k) % W];
    return o;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_order = 0; m_data = '0; m_valid = 0; m_ovr = 0; m_aln = 0;
    for (int i = 0; i < W; i++) m_bits[i] = 0;
  endtask

  task automatic model_edge();
    bit done;
    logic [W-1:0] word;
    done = 0;
    word = '0;
    if (clear) begin
      model_reset();
      return;
    end
    if (bus.bit_valid) begin
      if (bus.frame_start && m_cnt != 0) m_aln = 1;
      if (bus.frame_start || m_cnt == 0) begin
        m_cnt = 0;
        m_order = msb_first;
      end
      m_bits[m_cnt] = bus.serial_in;
      m_cnt++;
      if (m_cnt == W) begin
        done = 1;
        word = rotr(assemble(m_order), int'(rot_amt));
        m_cnt = 0;
      end
    end
    if (done) begin
      if (!m_valid || bus.out_ready) begin
        m_data = word;
        m_valid = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (m_valid && bus.out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic compare_all();
    check_val("bit_count", 64'(bit_count), 64'(m_cnt));
    check_val("out_valid", 64'(bus.out_valid), 64'(m_valid));
    check_val("out_data", 64'(bus.out_data), 64'(m_data));
    check_val("overrun", 64'(overrun), 64'(m_ovr));
    check_val("align_err", 64'(align_err), 64'(m_aln));
  endtask

  task automatic cycle(input bit c, input bit bv, input bit fs, input bit si,
                       input bit msb, input int rot, input bit rdy);
    clear = c;
    bus.bit_valid = bv;
    bus.frame_start = fs;
    bus.serial_in = si;
    msb_first = msb;
    rot_amt = RW'(rot);
    bus.out_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Stream bits in listed order: val[W-1] first.
  task automatic send_word(input logic [W-1:0] val, input bit msb, input int rot, input bit rdy);
    for (int i = 0; i < W; i++) cycle(0, 1, 0, val[W-1-i], msb, rot, rdy);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_data"}, 64'(bus.out_data), 64'h0);
    check_val({tag, "_valid"}, 64'(bus.out_valid), 64'h0);
    check_val({tag, "_cnt"}, 64'(bit_count), 64'h0);
    check_val({tag, "_ovr"}, 64'(overrun), 64'h0);
    check_val({tag, "_aln"}, 64'(align_err), 64'h0);
  endtask

  logic [W-1:0] wv;

  initial begin
    rst_n = 1'b0;
    clear = 1'b0; msb_first = 1'b0; rot_amt = '0;
    bus.bit_valid = 1'b0; bus.frame_start = 1'b0; bus.serial_in = 1'b0; bus.out_ready = 1'b0;
    model_reset();
    #2;
    check_zero("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    phase = "msb";
    send_word(8'hB2, 1, 0, 1);
    check_val("word", 64'(bus.out_data), 64'hB2);
    check_val("valid", 64'(bus.out_valid), 64'h1);

    phase = "rot3";
    send_word(8'hB2, 1, 3, 1);
    check_val("word", 64'(bus.out_data), 64'h56);

    phase = "lsb";
    send_word(8'hB2, 0, 0, 1);
    check_val("word", 64'(bus.out_data), 64'h4D);

    phase = "toggle";
    wv = 8'hB2;
    for (int i = 0; i < W; i++) cycle(0, 1, 0, wv[W-1-i], (i < 3), 0, 1);
    check_val("word", 64'(bus.out_data), 64'hB2);

    phase = "overrun";
    cycle(1, 0, 0, 0, 1, 0, 0);
    send_word(8'hB2, 1, 0, 0);
    send_word(8'h5A, 1, 0, 0);
    check_val("held", 64'(bus.out_data), 64'hB2);
    check_val("ovr", 64'(overrun), 64'h1);
    cycle(0, 0, 0, 0, 1, 0, 1);
    check_val("consumed", 64'(bus.out_valid), 64'h0);

    phase = "loadrdy";
    cycle(1, 0, 0, 0, 1, 0, 0);
    send_word(8'hB2, 1, 0, 0);
    wv = 8'h3C;
    for (int i = 0; i < W; i++) cycle(0, 1, 0, wv[W-1-i], 1, 0, (i == W - 1));
    check_val("word", 64'(bus.out_data), 64'h3C);
    check_val("valid", 64'(bus.out_valid), 64'h1);
    check_val("ovr", 64'(overrun), 64'h0);

    phase = "align";
    cycle(1, 0, 0, 0, 1, 0, 1);
    cycle(0, 1, 1, 0, 1, 0, 1);
    check_val("fs_at_zero", 64'(align_err), 64'h0);
    cycle(0, 1, 0, 1, 1, 0, 1);
    cycle(0, 1, 0, 1, 1, 0, 1);
    cycle(0, 1, 1, 1, 1, 0, 1);
    check_val("aln", 64'(align_err), 64'h1);
    check_val("cnt", 64'(bit_count), 64'h1);
    wv = 8'hA5;
    for (int i = 1; i < W; i++) cycle(0, 1, 0, wv[W-1-i], 1, 0, 1);
    check_val("word", 64'(bus.out_data), 64'hA5);
    check_val("valid", 64'(bus.out_valid), 64'h1);
    cycle(0, 1, 1, 0, 1, 0, 1);
    check_val("aln_kept", 64'(align_err), 64'h1);

    phase = "rstmid";
    cycle(0, 1, 0, 1, 1, 0, 1);
    cycle(0, 1, 0, 0, 1, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_zero("async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_word(8'hB2, 1, 0, 1);
    check_val("word", 64'(bus.out_data), 64'hB2);

    phase = "clearbv";
    send_word(8'h11, 1, 0, 0);
    send_word(8'h22, 1, 0, 0);
    cycle(0, 1, 0, 1, 1, 0, 0);
    cycle(0, 1, 0, 1, 1, 0, 0);
    cycle(1, 1, 0, 1, 1, 0, 0);
    check_zero("clr");
    send_word(8'hB2, 1, 0, 1);
    check_val("word", 64'(bus.out_data), 64'hB2);

    phase = "random";
    for (int n = 0; n < 800; n++) begin
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 99) < 75),
            ($urandom_range(0, 99) < 5),
            1'($urandom),
            1'($urandom),
            int'($urandom_range(0, (1 << RW) - 1)),
            ($urandom_range(0, 99) < 60));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
